uart_boot_loader: RTL and testbench
===================================

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning instruction-memory word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port uart_rx, input, 1 bit: serial line, 8N1, idle high, LSB first.
REQ-006 The block SHALL have port imem_we, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-007 The block SHALL have port imem_addr, output, ADDR_WIDTH bits: word address of the write.
REQ-008 The block SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-009 The block SHALL have port core_rst, output, 1 bit: active-high reset to the pipeline core, held while loading.
REQ-010 The block SHALL have port load_done, output, 1 bit: high once the image is fully written.
REQ-011 The block SHALL have port frame_err, output, 1 bit: sticky, set on any bad stop bit.

Function
REQ-012 uart_rx SHALL pass through a two-flop synchroniser before use; all receiver timing is measured from the synchronised signal.
REQ-013 The receiver SHALL be an FSM with states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-014 RX_IDLE -> RX_START on a synchronised high-to-low transition.
REQ-015 In RX_START, after CLKS_PER_BIT/2 cycles the line SHALL be sampled; low -> RX_DATA, high -> RX_IDLE (glitch rejected, no byte, no error).
REQ-016 In RX_DATA, eight bits SHALL be sampled at CLKS_PER_BIT-cycle intervals, LSB first, then -> RX_STOP.
REQ-017 In RX_STOP, after CLKS_PER_BIT cycles the line SHALL be sampled; high -> a one-cycle internal byte_valid with the byte, low -> byte discarded and frame_err set; either way -> RX_IDLE.
REQ-018 The loader SHALL be an FSM with states L_COUNT, L_LOAD, L_DONE, entered as L_COUNT on reset.
REQ-019 In L_COUNT, the first two valid bytes SHALL form a 16-bit word count N, low byte first.
REQ-020 On the second count byte: N=0 -> L_DONE; otherwise -> L_LOAD with word index 0 and byte index 0.
REQ-021 In L_LOAD, each group of four valid bytes SHALL form one word, first byte in bits [7:0], fourth in [31:24].
REQ-022 imem_we SHALL pulse high for exactly one cycle, the cycle after the fourth byte's byte_valid, with imem_wdata the assembled word and imem_addr the word index modulo 2^ADDR_WIDTH.
REQ-023 The word index SHALL increment after each write; addresses wrap to 0 past 2^ADDR_WIDTH-1, and N is not clamped.
REQ-024 After the write of word N-1, the loader SHALL enter L_DONE on the following cycle.
REQ-025 core_rst SHALL be high in L_COUNT and L_LOAD and low in L_DONE; load_done SHALL equal (state == L_DONE).
REQ-026 In L_DONE, received bytes SHALL be ignored; imem_we stays low until reset.
REQ-027 A framing-error byte SHALL NOT advance the count or byte index; loading continues with the next good byte.
REQ-028 imem_addr and imem_wdata SHALL hold their last written values between strobes.

Reset
REQ-029 While rst is low, asynchronously: both FSMs idle (RX_IDLE, L_COUNT), synchronisers high, all counters 0.
REQ-030 While rst is low: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, frame_err=0.
REQ-031 Reset asserted mid-byte or mid-load SHALL abandon the partial byte and word; the next load restarts at count byte 0, address 0.

Verification (CLKS_PER_BIT=4, ADDR_WIDTH=4)
REQ-032 Bytes 02 00, 13 05 10 00, 93 05 20 00 -> imem_we pulses at addr 0 with 0x00100513 and at addr 1 with 0x00200593; then core_rst=0 and load_done=1.
REQ-033 Bytes 00 00 -> no imem_we; core_rst falls and load_done rises one cycle after the second byte_valid.
REQ-034 2-cycle low glitch on uart_rx, then 01 00 AA BB CC DD -> glitch ignored; one write of 0xDDCCBBAA at addr 0; frame_err=0.
REQ-035 Count 01 00, byte 11 sent with stop bit low, then AA BB CC DD -> frame_err=1 and stays 1; single write of 0xDDCCBBAA.
REQ-036 Count 12 00 (18 words) -> words 16 and 17 are written at addr 0 and 1 (wrap); load_done after the 18th write.
REQ-037 rst pulsed low after 2 bytes of word 0, then a full 01 00 11 22 33 44 load -> core_rst held 1 throughout, single write 0x44332211 at addr 0.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an 8N1 byte stream (16-bit word count, then
// little-endian 32-bit words) and writes the words into instruction memory.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {L_COUNT, L_LOAD, L_DONE} ld_state_e;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;
  logic            frame_err_q, frame_err_d;

  ld_state_e             ld_state_q, ld_state_d;
  logic [15:0]           count_q, count_d;
  logic                  cnt_idx_q, cnt_idx_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  // rx_prev_q lets the idle state see a falling edge of the synchronised line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = frame_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Words are assembled by shifting bytes in from the top, so after three
  // bytes the first one sits in [7:0] and the fourth lands directly in [31:24].
  always_comb begin
    ld_state_d = ld_state_q;
    count_d    = count_q;
    cnt_idx_d  = cnt_idx_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (ld_state_q)
      L_COUNT: begin
        if (byte_vld_q) begin
          if (!cnt_idx_q) begin
            count_d[7:0] = byte_q;
            cnt_idx_d    = 1'b1;
          end else begin
            count_d[15:8] = byte_q;
            cnt_idx_d     = 1'b0;
            word_idx_d    = '0;
            byte_idx_d    = '0;
            ld_state_d    = ({byte_q, count_q[7:0]} == 16'd0) ? L_DONE : L_LOAD;
          end
        end
      end
      L_LOAD: begin
        if (byte_vld_q) begin
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {byte_q, word_buf_q};
            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
            word_idx_d = word_idx_q + 16'd1;
            byte_idx_d = '0;
          end else begin
            word_buf_d = {byte_q, word_buf_q[23:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        if (we_q && (word_idx_q == count_q)) ld_state_d = L_DONE;
      end
      L_DONE: ld_state_d = L_DONE;
      default: ld_state_d = L_COUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      ld_state_q  <= L_COUNT;
      count_q     <= '0;
      cnt_idx_q   <= 1'b0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_buf_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      ld_state_q  <= ld_state_d;
      count_q     <= count_d;
      cnt_idx_q   <= cnt_idx_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = (ld_state_q != L_DONE);
  assign load_done  = (ld_state_q == L_DONE);
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: stimulus pushes expected memory
// writes, a negedge monitor pops and compares each imem_we strobe.
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t sb[$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!load_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_load_done"}, {31'd0, load_done}, 32'd1);
    chk({name, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    // Outputs while reset is held
    repeat (3) @(negedge clk);
    chk("rst_we",        {31'd0, imem_we},   32'd0);
    chk("rst_addr",      {28'd0, imem_addr}, 32'd0);
    chk("rst_wdata",     imem_wdata,         32'd0);
    chk("rst_core_rst",  {31'd0, core_rst},  32'd1);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Two-word image
    expect_wr(4'd0, 32'h0010_0513);
    expect_wr(4'd1, 32'h0020_0593);
    send_byte(8'h02); send_byte(8'h00);
    chk("t1_core_rst_loading", {31'd0, core_rst}, 32'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    wait_done("t1");
    chk("t1_addr_hold",  {28'd0, imem_addr}, 32'd1);
    chk("t1_wdata_hold", imem_wdata, 32'h0020_0593);
    chk("t1_frame_err",  {31'd0, frame_err}, 32'd0);
    // Bytes after completion must not cause writes (monitor flags any)
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'h99);
    chk("t1_done_stays", {31'd0, load_done}, 32'd1);

    // Zero-length image
    do_reset();
    send_byte(8'h00);
    chk("t2_not_done_yet", {31'd0, load_done}, 32'd0);
    send_byte(8'h00);
    wait_done("t2");

    // Start-bit glitch is rejected
    do_reset();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("t3_glitch_no_err", {31'd0, frame_err}, 32'd0);
    expect_wr(4'd0, 32'hDDCC_BBAA);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done("t3");
    chk("t3_frame_err", {31'd0, frame_err}, 32'd0);

    // Framing error byte is dropped, error is sticky
    do_reset();
    expect_wr(4'd0, 32'hDDCC_BBAA);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11, 1'b0);
    chk("t4_frame_err_set", {31'd0, frame_err}, 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done("t4");
    chk("t4_frame_err_sticky", {31'd0, frame_err}, 32'd1);

    // 18 words: addresses wrap at 16
    do_reset();
    send_byte(8'h12); send_byte(8'h00);
    for (int i = 0; i < 18; i++) begin
      expect_wr(i[AW-1:0], {8'h7E, 8'hC3, 8'h5A, i[7:0]});
      send_byte(i[7:0]); send_byte(8'h5A); send_byte(8'hC3); send_byte(8'h7E);
      if (i == 16) chk("t5_not_done_at_17", {31'd0, load_done}, 32'd0);
    end
    wait_done("t5");
    chk("t5_last_addr", {28'd0, imem_addr}, 32'd1);

    // Reset mid-word and mid-byte, then a clean reload
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    chk("t6_core_rst_a", {31'd0, core_rst}, 32'd1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    rst     = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    chk("t6_core_rst_in_rst", {31'd0, core_rst}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_core_rst_b", {31'd0, core_rst}, 32'd1);
    expect_wr(4'd0, 32'h4433_2211);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33);
    chk("t6_core_rst_c", {31'd0, core_rst}, 32'd1);
    send_byte(8'h44);
    wait_done("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
